// File: rtl/kasumi_csr_pkg.sv
// +----------------------------------------------------------------------------+
// | kasumi_csr_pkg: shared machine-mode CSR addresses, mstatus fields, FSM enums |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package kasumi_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MSTATUS_MPP_LO = 11;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    T_EPC    = 3'd1,
    T_CAUSE  = 3'd2,
    T_TVAL   = 3'd3,
    T_STATUS = 3'd4,
    M_STATUS = 3'd5,
    REDIRECT = 3'd6
  } seq_state_e;

  typedef enum logic {
    KIND_TRAP = 1'b0,
    KIND_MRET = 1'b1
  } seq_kind_e;

endpackage

`default_nettype wire

// File: rtl/trap_sequencer_target_calc.sv
// +----------------------------------------------------------------------------+
// | trap_target_calc: combinational redirect target (direct / vectored mtvec)  |
// | Optional vectored mode enabled by macro TRAP_SEQ_VECTORED_EN               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module trap_target_calc
  import kasumi_csr_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_kind_mret,
  input  logic [XLEN-1:0] i_trap_vec,
  input  logic [XLEN-1:0] i_exception_pc,
  input  logic [XLEN-1:0] i_cause,
  output logic [XLEN-1:0] o_target
);

  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_trap_target;

  assign w_base = {i_trap_vec[XLEN-1:2], 2'b00};

`ifdef TRAP_SEQ_VECTORED_EN
  logic            w_vectored;
  logic [XLEN-1:0] w_offset;

  // Only asynchronous interrupts are dispatched through the vector table.
  assign w_vectored    = (i_trap_vec[1:0] == 2'b01) && i_cause[XLEN-1];
  assign w_offset      = {i_cause[XLEN-3:0], 2'b00};
  assign w_trap_target = w_vectored ? (w_base + w_offset) : w_base;
`else
  logic w_unused_ok;

  assign w_unused_ok   = ^{i_cause, i_trap_vec[1:0]};
  assign w_trap_target = w_base;
`endif

  assign o_target = i_kind_mret ? i_exception_pc : w_trap_target;

endmodule

`default_nettype wire

// File: rtl/trap_sequencer.sv
// +----------------------------------------------------------------------------+
// | trap_sequencer: serialises trap-entry / mret CSR updates, then redirects PC |
// | Optional vectored mtvec mode enabled by macro TRAP_SEQ_VECTORED_EN         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module trap_sequencer
  import kasumi_csr_pkg::*;
#(
  parameter int         XLEN     = 32,
  parameter logic [1:0] TRAP_MPP = 2'b11
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            mret_req,
  output logic            busy,
  output logic            csr_wb,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic [11:0]     csr_raddr,
  input  logic [XLEN-1:0] csr_rdata,
  input  logic [XLEN-1:0] trap_vec,
  input  logic [XLEN-1:0] exception_pc,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  seq_state_e      r_state;
  seq_state_e      w_state_nxt;
  seq_kind_e       r_kind;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_cause;
  logic [XLEN-1:0] r_tval;
  logic [XLEN-1:0] r_redirect_pc;

  logic            w_busy;
  logic            w_csr_wb;
  logic [11:0]     w_csr_waddr;
  logic [XLEN-1:0] w_csr_wdata;
  logic [11:0]     w_csr_raddr;
  logic            w_redirect_valid;
  logic [XLEN-1:0] w_mstatus_trap;
  logic [XLEN-1:0] w_mstatus_mret;
  logic [XLEN-1:0] w_target;

  always_comb begin
    w_mstatus_trap                                = csr_rdata;
    w_mstatus_trap[MSTATUS_MPIE]                  = csr_rdata[MSTATUS_MIE];
    w_mstatus_trap[MSTATUS_MIE]                   = 1'b0;
    w_mstatus_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = TRAP_MPP;
  end

  always_comb begin
    w_mstatus_mret                                = csr_rdata;
    w_mstatus_mret[MSTATUS_MIE]                   = csr_rdata[MSTATUS_MPIE];
    w_mstatus_mret[MSTATUS_MPIE]                  = 1'b1;
    w_mstatus_mret[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b00;
  end

  trap_target_calc #(
    .XLEN (XLEN)
  ) u_target_calc (
    .i_kind_mret    (r_kind == KIND_MRET),
    .i_trap_vec     (trap_vec),
    .i_exception_pc (exception_pc),
    .i_cause        (r_cause),
    .o_target       (w_target)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operands and kind are captured only when a sequence starts from IDLE;
  // requests arriving while busy leave them untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kind  <= KIND_TRAP;
      r_pc    <= '0;
      r_cause <= '0;
      r_tval  <= '0;
    end else if (r_state == IDLE) begin
      if (trap_req) begin
        r_kind  <= KIND_TRAP;
        r_pc    <= trap_pc;
        r_cause <= trap_cause;
        r_tval  <= trap_tval;
      end else if (mret_req) begin
        r_kind  <= KIND_MRET;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_redirect_pc <= '0;
    end else if (r_state == REDIRECT) begin
      r_redirect_pc <= w_target;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_busy           = 1'b1;
    w_csr_wb         = 1'b0;
    w_csr_waddr      = '0;
    w_csr_wdata      = '0;
    w_csr_raddr      = '0;
    w_redirect_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (trap_req) begin
          w_state_nxt = T_EPC;
        end else if (mret_req) begin
          w_state_nxt = M_STATUS;
        end
      end
      T_EPC: begin
        w_csr_wb    = 1'b1;
        w_csr_waddr = CSR_MEPC;
        w_csr_wdata = r_pc;
        w_state_nxt = T_CAUSE;
      end
      T_CAUSE: begin
        w_csr_wb    = 1'b1;
        w_csr_waddr = CSR_MCAUSE;
        w_csr_wdata = r_cause;
        w_state_nxt = T_TVAL;
      end
      T_TVAL: begin
        w_csr_wb    = 1'b1;
        w_csr_waddr = CSR_MTVAL;
        w_csr_wdata = r_tval;
        w_state_nxt = T_STATUS;
      end
      T_STATUS: begin
        w_csr_raddr = CSR_MSTATUS;
        w_csr_wb    = 1'b1;
        w_csr_waddr = CSR_MSTATUS;
        w_csr_wdata = w_mstatus_trap;
        w_state_nxt = REDIRECT;
      end
      M_STATUS: begin
        w_csr_raddr = CSR_MSTATUS;
        w_csr_wb    = 1'b1;
        w_csr_waddr = CSR_MSTATUS;
        w_csr_wdata = w_mstatus_mret;
        w_state_nxt = REDIRECT;
      end
      REDIRECT: begin
        w_redirect_valid = 1'b1;
        w_state_nxt      = IDLE;
      end
      default: begin
        w_busy      = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign busy           = w_busy;
  assign csr_wb         = w_csr_wb;
  assign csr_waddr      = w_csr_waddr;
  assign csr_wdata      = w_csr_wdata;
  assign csr_raddr      = w_csr_raddr;
  assign redirect_valid = w_redirect_valid;
  // Target is live during REDIRECT and held afterwards so fetch can re-read it.
  assign redirect_pc    = (r_state == REDIRECT) ? w_target : r_redirect_pc;

endmodule

`default_nettype wire

// File: tb/tb_trap_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_trap_sequencer: directed self-checking bench for trap_sequencer         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_trap_sequencer;

  logic        clk;
  logic        rst_n;
  logic        trap_req;
  logic [31:0] trap_pc;
  logic [31:0] trap_cause;
  logic [31:0] trap_tval;
  logic        mret_req;
  logic        busy;
  logic        csr_wb;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic [31:0] trap_vec;
  logic [31:0] exception_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int r_checks = 0;
  int r_errors = 0;

  trap_sequencer #(
    .XLEN     (32),
    .TRAP_MPP (2'b11)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .trap_req       (trap_req),
    .trap_pc        (trap_pc),
    .trap_cause     (trap_cause),
    .trap_tval      (trap_tval),
    .mret_req       (mret_req),
    .busy           (busy),
    .csr_wb         (csr_wb),
    .csr_waddr      (csr_waddr),
    .csr_wdata      (csr_wdata),
    .csr_raddr      (csr_raddr),
    .csr_rdata      (csr_rdata),
    .trap_vec       (trap_vec),
    .exception_pc   (exception_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    r_checks++;
    if (obs !== exp) begin
      r_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_write(input string tag, input logic [11:0] addr, input logic [31:0] data);
    check({tag, ".busy"},  busy, 1'b1);
    check({tag, ".wb"},    csr_wb, 1'b1);
    check({tag, ".waddr"}, csr_waddr, addr);
    check({tag, ".wdata"}, csr_wdata, data);
    check({tag, ".rv"},    redirect_valid, 1'b0);
  endtask

  task automatic check_idle(input string tag, input logic [31:0] held_pc);
    check({tag, ".busy"},  busy, 1'b0);
    check({tag, ".wb"},    csr_wb, 1'b0);
    check({tag, ".rv"},    redirect_valid, 1'b0);
    check({tag, ".rpc"},   redirect_pc, held_pc);
  endtask

  // Full trap sequence from IDLE. Optionally raises mret in the same cycle
  // or re-raises trap_req (with garbage operands) while in T_TVAL.
  task automatic run_trap(input string tag, input logic [31:0] pc, input logic [31:0] cause,
                          input logic [31:0] tval, input logic [31:0] rdata, input logic [31:0] vec,
                          input logic [31:0] exp_status, input logic [31:0] exp_target,
                          input bit with_mret, input bit retrigger);
    trap_pc    = pc;
    trap_cause = cause;
    trap_tval  = tval;
    csr_rdata  = rdata;
    trap_vec   = vec;
    trap_req   = 1'b1;
    mret_req   = with_mret;
    step();
    trap_req = 1'b0;
    mret_req = 1'b0;
    check_write({tag, ".epc"}, 12'h341, pc);
    step();
    check_write({tag, ".cause"}, 12'h342, cause);
    step();
    if (retrigger) begin
      trap_req   = 1'b1;
      trap_pc    = 32'hBAD0_0000;
      trap_cause = 32'h0000_000B;
      trap_tval  = 32'h1234_5678;
    end
    check_write({tag, ".tval"}, 12'h343, tval);
    step();
    trap_req = 1'b0;
    check_write({tag, ".status"}, 12'h300, exp_status);
    check({tag, ".raddr"}, csr_raddr, 12'h300);
    step();
    check({tag, ".redir.rv"},   redirect_valid, 1'b1);
    check({tag, ".redir.pc"},   redirect_pc, exp_target);
    check({tag, ".redir.wb"},   csr_wb, 1'b0);
    check({tag, ".redir.busy"}, busy, 1'b1);
    step();
    check_idle({tag, ".after"}, exp_target);
    step();
    check_idle({tag, ".after2"}, exp_target);
  endtask

  initial begin
    rst_n        = 1'b0;
    trap_req     = 1'b0;
    mret_req     = 1'b0;
    trap_pc      = '0;
    trap_cause   = '0;
    trap_tval    = '0;
    csr_rdata    = '0;
    trap_vec     = '0;
    exception_pc = '0;
    step();
    step();
    check_idle("reset", 32'h0);
    check("reset.waddr", csr_waddr, 12'h000);
    check("reset.wdata", csr_wdata, 32'h0);
    check("reset.raddr", csr_raddr, 12'h000);
    rst_n = 1'b1;
    step();
    check_idle("idle", 32'h0);

    run_trap("trap1", 32'h0000_0100, 32'h0000_0002, 32'hDEAD_BEEF, 32'h0000_0008,
             32'h0000_0200, 32'h0000_1880, 32'h0000_0200, 1'b0, 1'b0);

    exception_pc = 32'h0000_0104;
    csr_rdata    = 32'h0000_1880;
    mret_req     = 1'b1;
    step();
    mret_req = 1'b0;
    check_write("mret.status", 12'h300, 32'h0000_0088);
    check("mret.raddr", csr_raddr, 12'h300);
    step();
    check("mret.rv", redirect_valid, 1'b1);
    check("mret.pc", redirect_pc, 32'h0000_0104);
    check("mret.wb", csr_wb, 1'b0);
    step();
    check_idle("mret.after", 32'h0000_0104);

    // Reset asserted while the sequencer is in T_CAUSE.
    trap_pc    = 32'h0000_0400;
    trap_cause = 32'h0000_0005;
    trap_tval  = 32'h0000_0000;
    trap_vec   = 32'h0000_0200;
    trap_req   = 1'b1;
    step();
    trap_req = 1'b0;
    step();
    check("rstmid.in_cause", csr_waddr, 12'h342);
    rst_n = 1'b0;
    #1;
    check_idle("rstmid", 32'h0);
    check("rstmid.waddr", csr_waddr, 12'h000);
    check("rstmid.wdata", csr_wdata, 32'h0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("rstmid.no_rv", redirect_valid, 1'b0);
      check("rstmid.no_busy", busy, 1'b0);
    end

    run_trap("both", 32'h0000_0500, 32'h0000_0003, 32'h0000_0044, 32'h0000_0000,
             32'h0000_0300, 32'h0000_1800, 32'h0000_0300, 1'b1, 1'b0);

    run_trap("retrig", 32'h0000_0600, 32'h0000_0004, 32'hCAFE_0001, 32'h0000_1888,
             32'h0000_0200, 32'h0000_1880, 32'h0000_0200, 1'b0, 1'b1);

`ifdef TRAP_SEQ_VECTORED_EN
    run_trap("vec_irq", 32'h0000_0300, 32'h8000_0007, 32'h0000_0000, 32'h0000_0000,
             32'h0000_0201, 32'h0000_1800, 32'h0000_021C, 1'b0, 1'b0);
`else
    run_trap("vec_irq", 32'h0000_0300, 32'h8000_0007, 32'h0000_0000, 32'h0000_0000,
             32'h0000_0201, 32'h0000_1800, 32'h0000_0200, 1'b0, 1'b0);
`endif

    run_trap("vec_exc", 32'h0000_0700, 32'h0000_0002, 32'h0000_0011, 32'h0000_0008,
             32'h0000_0201, 32'h0000_1880, 32'h0000_0200, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", r_errors, r_checks);
    $finish;
  end

endmodule

`default_nettype wire
